// File: rtl/camray_gen.sv
// Per-column ray-direction generator: ray = dir + plane*cameraX for each screen column, streamed out.
// Optional build macro CAMRAY_HALFRES_EN: sweep every second column (0, 2, ..., W-2).
module camray_gen #(
  parameter int W     = 320,
  parameter int COL_W = 9,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    dir_x,
  input  logic [DW-1:0]    dir_y,
  input  logic [DW-1:0]    plane_x,
  input  logic [DW-1:0]    plane_y,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_col,
  output logic [DW-1:0]    ray_x,
  output logic [DW-1:0]    ray_y
);

  localparam int FRAC = 8;

`ifdef CAMRAY_HALFRES_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam logic [COL_W-1:0] STEP_C   = COL_W'(STEP);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - STEP);
  localparam logic [COL_W:0]   W_C      = (COL_W + 1)'(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [COL_W-1:0] issue_col_q, issue_col_d;
  logic [DW-1:0]    dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [DW-1:0]    plane_x_q, plane_x_d, plane_y_q, plane_y_d;

  logic             v1_q, v1_d;
  logic [COL_W-1:0] col1_q, col1_d;
  logic [DW-1:0]    cx_q, cx_d;

  logic               v2_q, v2_d;
  logic [COL_W-1:0]   col2_q, col2_d;
  logic [2*DW-1:0]    prod_x_q, prod_x_d, prod_y_q, prod_y_d;

  logic             out_valid_q, out_valid_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [DW-1:0]    ray_x_q, ray_x_d, ray_y_q, ray_y_d;
  logic             done_q, done_d;

  logic               stall;
  logic [DW-1:0]      rom_rd;
  logic signed [2*DW-1:0] px_ext, py_ext, cx_ext;

  // cameraX table, same content as camerax.rom: 2*x/W - 1 in Q8.8, truncated toward -inf from the +256 offset.
  logic [DW-1:0] rom [W];
  for (genvar g = 0; g < W; g++) begin : g_rom
    assign rom[g] = DW'((g * (2 << FRAC)) / W - (1 << FRAC));
  end

  assign stall = out_valid_q & ~out_ready;

  always_comb begin
    rom_rd = '0;
    if ({1'b0, issue_col_q} < W_C) begin
      rom_rd = rom[issue_col_q];
    end
    px_ext = {{DW{plane_x_q[DW-1]}}, plane_x_q};
    py_ext = {{DW{plane_y_q[DW-1]}}, plane_y_q};
    cx_ext = {{DW{cx_q[DW-1]}}, cx_q};
  end

  always_comb begin
    state_d     = state_q;
    issue_col_d = issue_col_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    plane_x_d   = plane_x_q;
    plane_y_d   = plane_y_q;
    v1_d        = v1_q;
    col1_d      = col1_q;
    cx_d        = cx_q;
    v2_d        = v2_q;
    col2_d      = col2_q;
    prod_x_d    = prod_x_q;
    prod_y_d    = prod_y_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    ray_x_d     = ray_x_q;
    ray_y_d     = ray_y_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_x_d     = dir_x;
          dir_y_d     = dir_y;
          plane_x_d   = plane_x;
          plane_y_d   = plane_y;
          issue_col_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          issue_col_d = issue_col_q + STEP_C;
          if (issue_col_q == LAST_COL) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready && out_col_q == LAST_COL) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The whole pipeline freezes together while the consumer holds off a beat.
    if (!stall) begin
      v1_d        = (state_q == RUN);
      col1_d      = issue_col_q;
      cx_d        = rom_rd;
      v2_d        = v1_q;
      col2_d      = col1_q;
      prod_x_d    = px_ext * cx_ext;
      prod_y_d    = py_ext * cx_ext;
      out_valid_d = v2_q;
      if (v2_q) begin
        out_col_d = col2_q;
        ray_x_d   = dir_x_q + prod_x_q[DW+FRAC-1:FRAC];
        ray_y_d   = dir_y_q + prod_y_q[DW+FRAC-1:FRAC];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_col_q <= '0;
      dir_x_q     <= '0;
      dir_y_q     <= '0;
      plane_x_q   <= '0;
      plane_y_q   <= '0;
      v1_q        <= 1'b0;
      col1_q      <= '0;
      cx_q        <= '0;
      v2_q        <= 1'b0;
      col2_q      <= '0;
      prod_x_q    <= '0;
      prod_y_q    <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      ray_x_q     <= '0;
      ray_y_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_col_q <= issue_col_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      plane_x_q   <= plane_x_d;
      plane_y_q   <= plane_y_d;
      v1_q        <= v1_d;
      col1_q      <= col1_d;
      cx_q        <= cx_d;
      v2_q        <= v2_d;
      col2_q      <= col2_d;
      prod_x_q    <= prod_x_d;
      prod_y_q    <= prod_y_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      ray_x_q     <= ray_x_d;
      ray_y_q     <= ray_y_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign ray_x     = ray_x_q;
  assign ray_y     = ray_y_q;

endmodule
